// File: rtl/riscv_mem_pkg.sv
// Shared widths, owner encoding and region-select bits for the unified
// instruction/data memory arbiter.
package riscv_mem_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_IMEM_ADDR_WIDTH = 9;
    localparam int DEF_DMEM_ADDR_WIDTH = 8;
    localparam int DEF_MAX_DSTREAK     = 4;

    // Top address bit of the unified memory selects the region.
    localparam logic REGION_IMEM = 1'b0;
    localparam logic REGION_DMEM = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_streak_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module mem_arb_streak_cnt #(
    parameter int P_MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = $clog2(P_MAX_DSTREAK + 1);

    logic [CNT_W-1:0] cnt;

    assign sat = (cnt == CNT_W'(P_MAX_DSTREAK));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one single-port memory:
// data wins by default, a waiting fetch is forced through after a streak limit.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int P_DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int P_IMEM_ADDR_WIDTH = DEF_IMEM_ADDR_WIDTH,
    parameter int P_DMEM_ADDR_WIDTH = DEF_DMEM_ADDR_WIDTH,
    parameter int P_MAX_DSTREAK     = DEF_MAX_DSTREAK
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req,
    input  logic [P_IMEM_ADDR_WIDTH-1:0] i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,
    output logic [P_DATA_WIDTH-1:0]      i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] d_addr,
    input  logic [P_DATA_WIDTH-1:0]      d_wdata,
    output logic                         d_gnt,
    output logic                         d_rvalid,
    output logic [P_DATA_WIDTH-1:0]      d_rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [P_IMEM_ADDR_WIDTH:0]   mem_addr,
    output logic [P_DATA_WIDTH-1:0]      mem_wdata,
    input  logic [P_DATA_WIDTH-1:0]      mem_rdata
);

    logic                         streak_sat;
    logic                         fetch_force;
    logic                         d_win;
    logic                         i_win;
    logic [P_IMEM_ADDR_WIDTH-1:0] d_addr_ext;
    owner_t                       owner;

    assign d_addr_ext  = P_IMEM_ADDR_WIDTH'(d_addr);
    assign fetch_force = i_req && streak_sat;
    assign d_win       = !reset && d_req && !fetch_force;
    assign i_win       = !reset && i_req && !d_win;

    always_comb begin
        i_gnt     = i_win;
        d_gnt     = d_win;
        mem_en    = d_win || i_win;
        mem_we    = d_win && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_win) begin
            mem_addr  = {REGION_DMEM, d_addr_ext};
            mem_wdata = d_wdata;
        end else if (i_win) begin
            mem_addr  = {REGION_IMEM, i_addr};
        end
    end

    // Only data grants taken over a pending fetch extend the streak.
    mem_arb_streak_cnt #(
        .P_MAX_DSTREAK(P_MAX_DSTREAK)
    ) u_streak (
        .clk  (clk),
        .reset(reset),
        .inc  (d_win && i_req),
        .clr  (i_win || !i_req),
        .sat  (streak_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else if (d_win && !d_we) begin
            owner <= OWN_D;
        end else if (i_win) begin
            owner <= OWN_I;
        end else begin
            owner <= OWN_NONE;
        end
    end

    // Gating with reset drops a read that was granted just before reset.
    assign i_rvalid = !reset && (owner == OWN_I);
    assign d_rvalid = !reset && (owner == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random plus directed stimulus for mem_arbiter, checked every cycle against a
// transaction-level model of grants, streak fairness and read return data.
module tb_mem_arbiter;

    localparam int DW    = 32;
    localparam int IAW   = 9;
    localparam int DAW   = 8;
    localparam int MAXS  = 4;
    localparam int MEM_N = 1 << (IAW + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           i_req;
    logic [IAW-1:0] i_addr;
    logic           i_gnt, i_rvalid;
    logic [DW-1:0]  i_rdata;
    logic           d_req, d_we;
    logic [DAW-1:0] d_addr;
    logic [DW-1:0]  d_wdata;
    logic           d_gnt, d_rvalid;
    logic [DW-1:0]  d_rdata;
    logic           mem_en, mem_we;
    logic [IAW:0]   mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .P_DATA_WIDTH(DW), .P_IMEM_ADDR_WIDTH(IAW),
        .P_DMEM_ADDR_WIDTH(DAW), .P_MAX_DSTREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(int a);
        return DW'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory responder: one-cycle read latency, garbage when no read was issued.
    initial begin
        logic [DW-1:0] mem [MEM_N];
        for (int a = 0; a < MEM_N; a++) mem[a] = init_word(a);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
            else                   mem_rdata <= $urandom;
            if (mem_en && mem_we)  mem[mem_addr] = mem_wdata;
        end
    end

    // Reference model: evaluated mid-cycle, then advanced to the next cycle.
    initial begin
        logic [DW-1:0] ref_mem [MEM_N];
        int            streak;
        int            pend;      // 0 none, 1 fetch read, 2 data read outstanding
        logic [DW-1:0] pend_data;
        bit            e_dg, e_ig;
        int            a;
        for (int k = 0; k < MEM_N; k++) ref_mem[k] = init_word(k);
        streak = 0;
        pend   = 0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_i_gnt", 64'(i_gnt), 0);
                check("rst_d_gnt", 64'(d_gnt), 0);
                check("rst_mem_en", 64'(mem_en), 0);
                check("rst_mem_we", 64'(mem_we), 0);
                check("rst_mem_addr", 64'(mem_addr), 0);
                check("rst_mem_wdata", 64'(mem_wdata), 0);
                check("rst_i_rvalid", 64'(i_rvalid), 0);
                check("rst_d_rvalid", 64'(d_rvalid), 0);
                streak = 0;
                pend   = 0;
            end else begin
                e_dg = d_req && !(i_req && streak >= MAXS);
                e_ig = i_req && !e_dg;
                a    = e_dg ? (MEM_N / 2) + int'(d_addr) : int'(i_addr);
                check("i_gnt", 64'(i_gnt), 64'(e_ig));
                check("d_gnt", 64'(d_gnt), 64'(e_dg));
                check("mem_en", 64'(mem_en), 64'(e_dg || e_ig));
                check("mem_we", 64'(mem_we), 64'(e_dg && d_we));
                if (e_dg || e_ig) check("mem_addr", 64'(mem_addr), 64'(a));
                if (e_dg) check("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
                check("i_rvalid", 64'(i_rvalid), 64'(pend == 1));
                check("d_rvalid", 64'(d_rvalid), 64'(pend == 2));
                if (pend == 1) check("i_rdata", 64'(i_rdata), 64'(pend_data));
                if (pend == 2) check("d_rdata", 64'(d_rdata), 64'(pend_data));
                pend = (e_dg && !d_we) ? 2 : (e_ig ? 1 : 0);
                if (pend != 0) pend_data = ref_mem[a];
                if (e_dg && d_we) ref_mem[a] = d_wdata;
                if (!i_req || e_ig)            streak = 0;
                else if (e_dg && streak < MAXS) streak++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] dpat, ipat;
        logic [8:0] drv_pat, irv_pat;
        logic [4:0] dpat5, ipat5;
        bit gi, gd;
        reset = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (3) next_cycle();
        reset = 1'b0;

        // Lone fetch: address map, then read data one cycle later.
        i_req = 1; i_addr = 9'h010;
        @(negedge clk);
        check("fetch_gnt", 64'(i_gnt), 1);
        check("fetch_addr", 64'(mem_addr), 64'h010);
        check("fetch_we", 64'(mem_we), 0);
        next_cycle();
        i_req = 0;
        @(negedge clk);
        check("fetch_rvalid", 64'(i_rvalid), 1);
        check("fetch_rdata", 64'(i_rdata), 64'(init_word(16)));

        // Lone store: region bit set, no rvalid afterwards.
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("store_gnt", 64'(d_gnt), 1);
        check("store_we", 64'(mem_we), 1);
        check("store_addr", 64'(mem_addr), 64'h220);
        check("store_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        next_cycle();
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("store_no_rvalid", 64'(i_rvalid || d_rvalid), 0);

        // Both requesting continuously: 4 data grants then 1 fetch, repeating.
        next_cycle();
        i_req = 1; i_addr = 9'h005; d_req = 1; d_we = 0; d_addr = 8'h01;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dpat[k] = d_gnt;
            ipat[k] = i_gnt;
            next_cycle();
        end
        check("streak_dpat", 64'(dpat), 64'b0111101111);
        check("streak_ipat", 64'(ipat), 64'b1000010000);
        i_req = 0; d_req = 0;

        // Alternating load/fetch: rvalid must alternate one cycle later.
        next_cycle();
        for (int k = 0; k < 9; k++) begin
            i_req = (k < 8) && (k % 2 == 1);
            d_req = (k < 8) && (k % 2 == 0);
            @(negedge clk);
            drv_pat[k] = d_rvalid;
            irv_pat[k] = i_rvalid;
            next_cycle();
        end
        check("alt_d_rvalid", 64'(drv_pat), 64'b010101010);
        check("alt_i_rvalid", 64'(irv_pat), 64'b101010100);

        // Build a streak of 3, reset right after a load grant, then re-measure.
        i_req = 1; d_req = 1; d_addr = 8'h03;
        repeat (3) next_cycle();
        reset = 1;
        @(negedge clk);
        check("rst_after_load_rvalid", 64'(d_rvalid), 0);
        check("rst_after_load_en", 64'(mem_en), 0);
        next_cycle();
        next_cycle();
        reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dpat5[k] = d_gnt;
            ipat5[k] = i_gnt;
            next_cycle();
        end
        check("post_rst_dpat", 64'(dpat5), 64'b01111);
        check("post_rst_ipat", 64'(ipat5), 64'b10000);
        i_req = 0; d_req = 0;

        // Random traffic obeying the hold-until-grant rule, with sparse resets.
        next_cycle();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            gi = i_gnt;
            gd = d_gnt;
            next_cycle();
            reset = ($urandom_range(0, 99) < 2);
            if (!i_req || gi) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = IAW'($urandom);
            end
            if (!d_req || gd) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = DAW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end
        reset = 0; i_req = 0; d_req = 0;
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
